instr_seq: RTL and testbench
============================

// Module: instr_seq
// PURPOSE
//   Instruction sequencer for the 8-bit-instruction core. Fetches one byte per
//   instruction from program memory over a req/ack handshake, holds it in the
//   instruction register feeding the decode controller (opcode = instr[7:4],
//   operand = instr[3:0]), and steps FETCH -> DECODE -> EXEC.
//   It also owns the PC, jumps, halt/resume, and an execute-timeout fault.
// PARAMETERS
//   ADDR_W    12      PC / program memory address width
//   RST_VEC   0       PC value loaded on reset (ADDR_W bits)
//   HALT_OP   4'hF    opcode that halts the core after it executes
//   MAX_EXEC  15      max EXEC cycles without exec_done before fault (>=1)
// PORTS
//   clk        in   1       single clock, all state on rising edge
//   rst        in   1       synchronous, active-high reset
//   mem_req    out  1       fetch request to program memory
//   mem_addr   out  ADDR_W  fetch address (= pc while mem_req)
//   mem_ack    in   1       memory accepts request; mem_rdata valid same cycle
//   mem_rdata  in   8       fetched instruction byte
//   instr      out  8       instruction register, to decode controller
//   exec_en    out  1       high every cycle state is EXEC
//   exec_done  in   1       datapath finished current instruction
//   jmp_en     in   1       take jump; sampled only with exec_done in EXEC
//   jmp_addr   in   ADDR_W  jump target
//   halt       in   1       external halt request (level or pulse)
//   run        in   1       resume from HALT
//   pc         out  ADDR_W  program counter
//   halted     out  1       high while in HALT
//   fault      out  1       sticky: EXEC timeout occurred
// BEHAVIOUR
//   States: FETCH, DECODE, EXEC, HALT. Reset -> FETCH; pc=RST_VEC, instr=8'h00,
//   mem_req=0, exec_en=0, halted=0, fault=0, halt_pend=0, exec counter=0.
//   mem_req registered: rises the cycle after entering FETCH, held high with
//   mem_addr stable until mem_ack. mem_ack while mem_req=0 is ignored.
//   FETCH: on mem_req&mem_ack: instr<=mem_rdata, pc<=pc+1 (wraps modulo
//   2^ADDR_W, all-ones -> 0), mem_req<=0, -> DECODE.
//   DECODE: exactly 1 cycle, instr stable -> EXEC.
//   EXEC: exec_en=1; counter increments each cycle. On exec_done:
//     jmp_en=1 -> pc<=jmp_addr (overrides the fetch increment);
//     then opcode==HALT_OP or halt_pend -> HALT, else -> FETCH; counter<=0.
//   Timeout: counter reaches MAX_EXEC without exec_done -> fault<=1, -> HALT
//   (pc unchanged, jmp ignored). exec_done on that same cycle wins: no fault.
//   halt: sets halt_pend any cycle; honoured only at instruction boundary
//   (EXEC completion); halt_pend cleared on entering HALT.
//   HALT: halted=1, exec_en=0, mem_req=0. run=1 & halt=0 -> FETCH, fault<=0.
//   run outside HALT is ignored. run&halt together in HALT: stay in HALT.
//   Minimum throughput: 4 cycles/instr (FETCH req, ack, DECODE, EXEC 1 cycle).
//   rst mid-fetch or mid-EXEC: drops mem_req next edge, aborts instruction,
//   returns to reset values; no pending state survives.
// TESTING
//   Reset, memory acks every request immediately, exec_done 1 cycle after
//   exec_en: bytes 0x12,0x34 at 0,1 -> instr 0x12 then 0x34, pc 1 then 2,
//   exec_en one cycle per instr, 4-cycle cadence.
//   mem_ack delayed 3 cycles -> mem_req/mem_addr held stable, instr unchanged
//   until ack; stray mem_ack in DECODE/EXEC has no effect.
//   exec_done with jmp_en, jmp_addr=0x0A5 -> next mem_addr 0x0A5; pc=0xFFF with
//   ADDR_W=12, no jump -> next fetch address 0x000.
//   Fetch 0xF3 (HALT_OP) -> halted=1 after exec_done, pc = addr+1; run pulse
//   -> FETCH resumes there. halt pulse mid-EXEC -> halts after that instr.
//   Withhold exec_done -> fault=1 and halted=1 after MAX_EXEC EXEC cycles;
//   exec_done exactly on cycle MAX_EXEC -> no fault; run clears fault.
//   Assert rst while mem_req high and while in EXEC -> all outputs at reset
//   values the cycle after, first fetch from RST_VEC.

Source files
------------

// File: rtl/instr_seq.sv
// Instruction sequencer: fetches one byte per instruction over req/ack, steps
// FETCH -> DECODE -> EXEC, and owns the PC, jumps, halt/resume and exec timeout.
module instr_seq #(
  parameter int          ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RST_VEC = '0,
  parameter logic [3:0]  HALT_OP  = 4'hF,
  parameter int          MAX_EXEC = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        instr,
  output logic              exec_en,
  input  logic              exec_done,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              halt,
  input  logic              run,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fault
);

  localparam int CNT_W = $clog2(MAX_EXEC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_EXEC - 1);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pc_reg, pc_next;
  logic [7:0]          instr_reg, instr_next;
  logic                mem_req_reg, mem_req_next;
  logic                fault_reg, fault_next;
  logic                halt_pend_reg, halt_pend_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                halt_any;
  logic                is_halt_op;

  assign halt_any   = halt_pend_reg | halt;
  assign is_halt_op = (instr_reg[7:4] == HALT_OP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= FETCH;
      pc_reg        <= RST_VEC;
      instr_reg     <= 8'h00;
      mem_req_reg   <= 1'b0;
      fault_reg     <= 1'b0;
      halt_pend_reg <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      instr_reg     <= instr_next;
      mem_req_reg   <= mem_req_next;
      fault_reg     <= fault_next;
      halt_pend_reg <= halt_pend_next;
      cnt_reg       <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    instr_next   = instr_reg;
    mem_req_next = mem_req_reg;
    fault_next   = fault_reg;
    cnt_next     = cnt_reg;

    unique case (state_reg)
      FETCH: begin
        // Request goes out one cycle after entering FETCH and holds until ack.
        if (mem_req_reg && mem_ack) begin
          instr_next   = mem_rdata;
          pc_next      = pc_reg + ADDR_W'(1);
          mem_req_next = 1'b0;
          state_next   = DECODE;
        end else begin
          mem_req_next = 1'b1;
        end
      end

      DECODE: begin
        cnt_next   = '0;
        state_next = EXEC;
      end

      EXEC: begin
        // A completion on the last allowed cycle beats the timeout.
        if (exec_done) begin
          if (jmp_en) begin
            pc_next = jmp_addr;
          end
          cnt_next   = '0;
          state_next = (is_halt_op || halt_any) ? HALT : FETCH;
        end else if (cnt_reg == CNT_LAST) begin
          fault_next = 1'b1;
          cnt_next   = '0;
          state_next = HALT;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      HALT: begin
        mem_req_next = 1'b0;
        if (run && !halt) begin
          fault_next = 1'b0;
          state_next = FETCH;
        end
      end

      default: begin
        state_next = FETCH;
      end
    endcase

    // A pending halt is consumed by entering HALT; requests seen while halted
    // must not carry over into the resumed program.
    halt_pend_next = (state_next == HALT) ? 1'b0 : halt_any;
  end

  assign mem_req  = mem_req_reg;
  assign mem_addr = pc_reg;
  assign instr    = instr_reg;
  assign pc       = pc_reg;
  assign exec_en  = (state_reg == EXEC);
  assign halted   = (state_reg == HALT);
  assign fault    = fault_reg;

endmodule

// File: tb/tb_instr_seq.sv
// Directed bench for instr_seq: fetch cadence, ack stalls, jumps, PC wrap,
// halt/resume, execute timeout and mid-operation reset.
module tb_instr_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [7:0]  instr;
  logic        exec_en;
  logic        exec_done;
  logic        jmp_en;
  logic [11:0] jmp_addr;
  logic        halt;
  logic        run;
  logic [11:0] pc;
  logic        halted;
  logic        fault;

  logic [7:0]  mem_img [0:4095];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  instr_seq #(
    .ADDR_W  (12),
    .RST_VEC (12'h000),
    .HALT_OP (4'hF),
    .MAX_EXEC(15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .instr    (instr),
    .exec_en  (exec_en),
    .exec_done(exec_done),
    .jmp_en   (jmp_en),
    .jmp_addr (jmp_addr),
    .halt     (halt),
    .run      (run),
    .pc       (pc),
    .halted   (halted),
    .fault    (fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      $display("vec %0d %s: observed %0h expected %0h ok", vectors, tag, obs, exp);
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic ack, input logic done, input logic jmp,
                      input logic [11:0] ja, input logic hl, input logic rn);
    mem_ack   = ack;
    exec_done = done;
    jmp_en    = jmp;
    jmp_addr  = ja;
    halt      = hl;
    run       = rn;
    mem_rdata = mem_img[mem_addr];
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".mem_req"}, 32'(mem_req), 32'h0);
    chk({tag, ".pc"},      32'(pc),      32'h000);
    chk({tag, ".instr"},   32'(instr),   32'h00);
    chk({tag, ".exec_en"}, 32'(exec_en), 32'h0);
    chk({tag, ".halted"},  32'(halted),  32'h0);
    chk({tag, ".fault"},   32'(fault),   32'h0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem_img[i] = 8'h00;
    mem_img[12'h000] = 8'h12;
    mem_img[12'h001] = 8'h34;
    mem_img[12'h002] = 8'h56;
    mem_img[12'h0A5] = 8'h20;
    mem_img[12'hFFF] = 8'h21;
    mem_img[12'h010] = 8'hF3;
    mem_img[12'h011] = 8'h40;
    mem_img[12'h012] = 8'h50;
    mem_img[12'h013] = 8'h60;
    mem_img[12'h014] = 8'h70;

    rst = 1'b1;
    idle();
    idle();
    chk_reset("reset");
    rst = 1'b0;

    // Back-to-back instructions with immediate ack and immediate done.
    idle();
    chk("i0.req", 32'(mem_req), 32'h1);
    chk("i0.addr", 32'(mem_addr), 32'h000);
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("i0.instr", 32'(instr), 32'h12);
    chk("i0.pc", 32'(pc), 32'h001);
    chk("i0.req_drop", 32'(mem_req), 32'h0);
    chk("i0.decode_no_exec", 32'(exec_en), 32'h0);
    idle();
    chk("i0.exec_en", 32'(exec_en), 32'h1);
    step(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("i0.exec_one_cycle", 32'(exec_en), 32'h0);
    chk("i0.back_fetch_req", 32'(mem_req), 32'h0);
    idle();
    chk("i1.addr", 32'(mem_addr), 32'h001);
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("i1.instr", 32'(instr), 32'h34);
    chk("i1.pc", 32'(pc), 32'h002);
    idle();
    chk("i1.exec_en", 32'(exec_en), 32'h1);
    step(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0);

    // Ack withheld for three cycles: request and address must hold.
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("stall.req", 32'(mem_req), 32'h1);
      chk("stall.addr", 32'(mem_addr), 32'h002);
      chk("stall.instr", 32'(instr), 32'h34);
    end
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("stall.instr_after_ack", 32'(instr), 32'h56);
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("stray_dec.pc", 32'(pc), 32'h003);
    chk("stray_dec.instr", 32'(instr), 32'h56);
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("stray_exec.pc", 32'(pc), 32'h003);
    chk("stray_exec.exec_en", 32'(exec_en), 32'h1);
    chk("stray_exec.req", 32'(mem_req), 32'h0);

    // Jump to 0x0A5, then to 0xFFF to observe the PC wrap.
    step(1'b0, 1'b1, 1'b1, 12'h0A5, 1'b0, 1'b0);
    chk("jmp.pc", 32'(pc), 32'h0A5);
    idle();
    chk("jmp.addr", 32'(mem_addr), 32'h0A5);
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("jmp.instr", 32'(instr), 32'h20);
    idle();
    step(1'b0, 1'b1, 1'b1, 12'hFFF, 1'b0, 1'b0);
    idle();
    chk("wrap.addr_fff", 32'(mem_addr), 32'hFFF);
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("wrap.instr", 32'(instr), 32'h21);
    chk("wrap.pc", 32'(pc), 32'h000);
    idle();
    step(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
    idle();
    chk("wrap.next_addr", 32'(mem_addr), 32'h000);

    // HALT_OP at 0x010: halts with pc at the following byte.
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    idle();
    step(1'b0, 1'b1, 1'b1, 12'h010, 1'b0, 1'b0);
    idle();
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("hop.instr", 32'(instr), 32'hF3);
    idle();
    step(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("hop.halted", 32'(halted), 32'h1);
    chk("hop.pc", 32'(pc), 32'h011);
    chk("hop.exec_en", 32'(exec_en), 32'h0);
    chk("hop.req", 32'(mem_req), 32'h0);
    idle();
    chk("hop.stays", 32'(halted), 32'h1);
    step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
    chk("hop.run_and_halt", 32'(halted), 32'h1);
    step(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    chk("hop.resumed", 32'(halted), 32'h0);
    idle();
    chk("hop.resume_addr", 32'(mem_addr), 32'h011);
    chk("hop.resume_req", 32'(mem_req), 32'h1);

    // External halt pulse mid-EXEC takes effect at instruction end.
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    idle();
    step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    chk("hpulse.still_exec", 32'(exec_en), 32'h1);
    chk("hpulse.not_halted", 32'(halted), 32'h0);
    step(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("hpulse.halted", 32'(halted), 32'h1);
    chk("hpulse.pc", 32'(pc), 32'h012);
    step(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    idle();
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    idle();
    step(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("hpulse.no_repeat", 32'(halted), 32'h0);

    // Timeout: exec_done never arrives within 15 EXEC cycles.
    idle();
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    idle();
    for (int i = 1; i < 15; i++) begin
      step(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    end
    chk("tmo.pre_exec", 32'(exec_en), 32'h1);
    chk("tmo.pre_fault", 32'(fault), 32'h0);
    step(1'b0, 1'b0, 1'b1, 12'h300, 1'b0, 1'b0);
    chk("tmo.fault", 32'(fault), 32'h1);
    chk("tmo.halted", 32'(halted), 32'h1);
    chk("tmo.pc", 32'(pc), 32'h014);
    idle();
    chk("tmo.sticky", 32'(fault), 32'h1);
    step(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    chk("tmo.run_clears", 32'(fault), 32'h0);
    chk("tmo.run_unhalt", 32'(halted), 32'h0);

    // exec_done on exactly the 15th EXEC cycle completes normally.
    idle();
    chk("edge.addr", 32'(mem_addr), 32'h014);
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    idle();
    for (int i = 1; i < 15; i++) begin
      step(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("edge.no_fault", 32'(fault), 32'h0);
    chk("edge.no_halt", 32'(halted), 32'h0);
    chk("edge.pc", 32'(pc), 32'h015);

    // Reset while mem_req is high.
    idle();
    chk("rfetch.req_before", 32'(mem_req), 32'h1);
    rst = 1'b1;
    idle();
    chk_reset("rfetch");
    rst = 1'b0;

    // Reset while in EXEC with a halt pending.
    idle();
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    idle();
    step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    chk("rexec.in_exec", 32'(exec_en), 32'h1);
    rst = 1'b1;
    idle();
    chk_reset("rexec");
    rst = 1'b0;
    idle();
    chk("rexec.first_addr", 32'(mem_addr), 32'h000);
    chk("rexec.first_req", 32'(mem_req), 32'h1);
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("rexec.instr", 32'(instr), 32'h12);
    idle();
    step(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("rexec.no_pend_halt", 32'(halted), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
